uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one uart_tx serialiser between N_REQ on-chip requesters (e.g. drive status, tray sensor, nav ack).
//  Arbitrates round-robin. Wraps each granted byte in a 4-byte frame so the Nano can demux by source:
//    frame = SYNC_BYTE, ID, DATA, CSUM
//  Sits between the requesters and uart_tx. Drives uart_tx data_tx/valid_in and consumes its ready_out.
// PARAMETERS
//  N_REQ      4      number of requesters, legal range 2..16
//  SYNC_BYTE  8'hA5  first byte of every frame
// PORTS
//  clk        in   1          system clock (CLOCK2_50 domain)
//  rst        in   1          asynchronous, active-low reset
//  req_valid  in   N_REQ      requester i holds a byte to send
//  req_data   in   8*N_REQ    requester i byte is at [8*i+7:8*i]
//  req_ready  out  N_REQ      one-hot, one-cycle grant/accept of requester byte
//  tx_data    out  8          to uart_tx data_tx
//  tx_valid   out  1          to uart_tx valid_in
//  tx_ready   in   1          from uart_tx ready_out
//  busy       out  1          high while a frame is in progress (any state except IDLE)
//  grant_id   out  4          index of the requester owning the current frame
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, tx_valid=0, tx_data=0, busy=0, grant_id=0, rr_ptr=0, latched data=0.
//    req_ready=0 for the whole time rst=0.
//  Handshakes:
//    Requester side: the byte transfers on a cycle where req_valid[i] & req_ready[i].
//    UART side: a byte transfers on a cycle where tx_valid & tx_ready.
//    Once tx_valid rises, it and tx_data stay stable until that transfer.
//  FSM: IDLE -> SYNC -> ID -> DATA -> CSUM -> IDLE.
//  IDLE
//    If any req_valid: req_ready[g]=1 combinationally, where g is the first set bit searched from rr_ptr upward, wrapping.
//    On that edge: latch req_data[g] and set grant_id=g. Set rr_ptr=(g+1) mod N_REQ; wrap at N_REQ, not at 16.
//    Go to SYNC. With no request pending, stay in IDLE and keep req_ready=0.
//  SYNC/ID/DATA/CSUM
//    tx_valid=1. tx_data is, per state:
//      SYNC: SYNC_BYTE
//      ID:   {4'h0,grant_id}
//      DATA: latched byte
//      CSUM: SYNC_BYTE ^ {4'h0,grant_id} ^ latched byte
//    Advance on each tx handshake. Leave CSUM for IDLE on its handshake, with tx_valid=0 in IDLE.
//  Latency
//    req grant edge -> tx_valid=1 on the next cycle. Frame ends 1 cycle after the CSUM handshake.
//    Earliest next grant is in that IDLE cycle; there is no back-to-back frame without 1 IDLE cycle.
//  req_ready is only asserted in IDLE. Requests arriving mid-frame wait and are never dropped.
//  A requester may deassert req_valid before it is granted. It is then skipped.
//  Simultaneous requests: strict round-robin, so every continuously valid requester is granted within N_REQ frames.
//  tx_ready low for an unbounded time: stall in the current state and keep outputs held. There is no timeout.
//  Reset mid-frame: async abort to IDLE. A partial frame is allowed, because the Nano resyncs on SYNC_BYTE.
//    uart_tx shares rst.
//  Width rules: grant_id is 4 bits regardless of N_REQ. The checksum is a plain 8-bit XOR with no carry.
// STRUCTURE
//  Package uart_sched_pkg:
//    typedef enum logic [2:0] {IDLE,SYNC,ID,DATA,CSUM} sched_state_t
//    localparam DEFAULT_SYNC=8'hA5, ID_W=4
//    function frame_csum(sync,id,data)
//  Sub-module rr_arbiter #(N):
//    inputs req[N], ptr[$clog2(N)], en
//    outputs one-hot gnt[N] and gnt_idx
//    purely combinational. rr_ptr is owned by uart_tx_scheduler.
// TESTING
//  1. Reset, then req_valid=4'b0001 with data 8'h3C and tx_ready always 1.
//     Expect tx bytes A5,00,3C,99. req_ready[0] for exactly 1 cycle. busy high 4 cycles.
//  2. All four valid continuously, data_i=8'h10*i, tx_ready=1.
//     Expect grant order 0,1,2,3,0. ID bytes 00,01,02,03,00. Each CSUM is the XOR of its frame.
//  3. tx_ready low for 20 cycles during the DATA byte.
//     Expect tx_valid=1 and tx_data unchanged throughout. The frame completes after tx_ready rises.
//  4. Requester 2 raises req_valid during requester 1's frame.
//     Expect req_ready[2]=0 until IDLE. Then grant 2 with id byte 02.
//  5. Assert rst low while in the ID state.
//     Expect tx_valid=0, busy=0 and req_ready=0 in the same cycle, before any edge.
//     After release the next frame starts with A5 and rr_ptr is 0.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler: FSM state encoding,
// frame constants and the frame checksum.
package uart_sched_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, ID, DATA, CSUM} sched_state_t;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
    localparam int         ID_W         = 4;

    // Plain 8-bit XOR, no carry, so the receiver can check it byte by byte.
    function automatic logic [7:0] frame_csum(input logic [7:0] sync,
                                              input logic [7:0] id,
                                              input logic [7:0] data);
        return sync ^ id ^ data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request found
// searching upward from ptr, wrapping at N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between N_REQ requesters; each granted byte is sent as a
// SYNC, ID, DATA, CSUM frame so the receiver can demux by source.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int          N_REQ     = 4,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    localparam int PTR_W = $clog2(N_REQ);

    sched_state_t      state_q, state_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]        data_q, data_d;

    logic [N_REQ-1:0]  gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              hs;

    // Grants only in IDLE, and never while reset is asserted.
    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      ((state_q == IDLE) && rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign hs = tx_valid_q & tx_ready;

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        data_d     = data_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    data_d     = req_data[8*int'(gnt_idx) +: 8];
                    grant_id_d = ID_W'(gnt_idx);
                    rr_ptr_d   = (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
                    state_d    = SYNC;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                end
            end
            SYNC: if (hs) begin
                state_d   = ID;
                tx_data_d = {4'h0, grant_id_q};
            end
            ID: if (hs) begin
                state_d   = DATA;
                tx_data_d = data_q;
            end
            DATA: if (hs) begin
                state_d   = CSUM;
                tx_data_d = frame_csum(SYNC_BYTE, {4'h0, grant_id_q}, data_q);
            end
            CSUM: if (hs) begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = '0;
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            data_q     <= data_d;
        end
    end

    assign req_ready = gnt;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a frame-queue reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_uart_tx_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           busy;
    logic [3:0]     grant_id;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(N), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    int total = 0;
    int bad   = 0;

    bit chk_en        = 0;
    bit drop_on_grant = 0;

    // Reference model: bytes still owed by the current frame, next search start, owner.
    logic [7:0] mq[$];
    int         mptr = 0;
    int         mid  = 0;

    logic [7:0] txlog[$];
    int         grants[$];
    int         cnt_rdy0 = 0;
    int         cnt_busy = 0;
    logic [N-1:0] last_rdy = '0;

    int         mg;
    logic [N-1:0] mer;
    logic [7:0] md;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst) begin
            last_rdy = req_ready;
            if (req_ready[0]) cnt_rdy0++;
            if (busy) cnt_busy++;
            for (int k = 0; k < N; k++) if (req_ready[k]) grants.push_back(k);
            if (mq.size() == 0) begin
                mg  = -1;
                mer = '0;
                for (int k = 0; k < N; k++)
                    if (mg < 0 && req_valid[(mptr + k) % N]) mg = (mptr + k) % N;
                if (mg >= 0) mer[mg] = 1'b1;
                chk("idle_tx_valid", tx_valid, 0);
                chk("idle_busy", busy, 0);
                chk("idle_req_ready", req_ready, mer);
                if (mg >= 0) begin
                    md = req_data[8*mg +: 8];
                    mq.push_back(8'hA5);
                    mq.push_back(mg[7:0]);
                    mq.push_back(md);
                    mq.push_back(8'hA5 ^ mg[7:0] ^ md);
                    mid  = mg;
                    mptr = (mg + 1) % N;
                end
            end else begin
                chk("frame_tx_valid", tx_valid, 1);
                chk("frame_tx_data", tx_data, mq[0]);
                chk("frame_busy", busy, 1);
                chk("frame_req_ready", req_ready, 0);
                chk("frame_grant_id", grant_id, mid);
                if (tx_ready) begin
                    txlog.push_back(tx_data);
                    void'(mq.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (drop_on_grant) req_valid = req_valid & ~last_rdy;
    endtask

    task automatic run_until(input int nbytes, input int budget, input string nm);
        int n;
        n = 0;
        while ((txlog.size() < nbytes || busy) && n < budget) begin
            cyc();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: timeout, %0d bytes seen, %0d required", nm, txlog.size(), nbytes);
        end
    endtask

    // Called at posedge+1; aborts asynchronously mid-cycle and restarts the model.
    task automatic async_reset(input string nm);
        #2;
        chk_en = 0;
        rst    = 1'b0;
        #1;
        chk({nm, "_tx_valid"}, tx_valid, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_req_ready"}, req_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        mq.delete();
        mptr = 0;
        mid  = 0;
        rst  = 1'b1;
        chk_en = 1;
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        req_valid = 4'b0001;
        req_data  = '0;
        req_data[7:0] = 8'h3C;
        tx_ready  = 1'b1;
        #12;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_ready", req_ready, 0);

        // Single requester, uart always ready.
        @(posedge clk);
        #1;
        rst = 1'b1;
        drop_on_grant = 1;
        chk_en = 1;
        run_until(4, 40, "t1_done");
        chk("t1_b0", txlog[0], 8'hA5);
        chk("t1_b1", txlog[1], 8'h00);
        chk("t1_b2", txlog[2], 8'h3C);
        chk("t1_b3", txlog[3], 8'h99);
        chk("t1_rdy_cycles", cnt_rdy0, 1);
        chk("t1_busy_cycles", cnt_busy, 4);

        // Uart stalls for 20 cycles on the DATA byte.
        txlog.delete();
        grants.delete();
        req_data[15:8] = 8'h5A;
        req_valid = 4'b0010;
        n = 0;
        while (txlog.size() < 2 && n < 20) begin cyc(); n++; end
        chk("t3_reach_data", txlog.size(), 2);
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t3_hold_valid", tx_valid, 1);
            chk("t3_hold_data", tx_data, 8'h5A);
        end
        tx_ready = 1'b1;
        run_until(4, 20, "t3_done");
        chk("t3_b0", txlog[0], 8'hA5);
        chk("t3_b1", txlog[1], 8'h01);
        chk("t3_b2", txlog[2], 8'h5A);
        chk("t3_b3", txlog[3], 8'hFE);

        // Requester 2 arrives while requester 1's frame is in flight.
        txlog.delete();
        grants.delete();
        req_data[15:8] = 8'h77;
        req_data[23:16] = 8'h42;
        req_valid = 4'b0010;
        n = 0;
        while (grants.size() < 1 && n < 20) begin cyc(); n++; end
        req_valid[2] = 1'b1;
        run_until(8, 60, "t4_done");
        chk("t4_grant0", grants[0], 1);
        chk("t4_grant1", grants[1], 2);
        chk("t4_id0", txlog[1], 8'h01);
        chk("t4_id1", txlog[5], 8'h02);
        chk("t4_data1", txlog[6], 8'h42);
        chk("t4_csum1", txlog[7], 8'hA5 ^ 8'h02 ^ 8'h42);

        // Reset while the ID byte is pending.
        txlog.delete();
        grants.delete();
        drop_on_grant = 0;
        req_data[7:0] = 8'h11;
        req_valid = 4'b0001;
        n = 0;
        while (txlog.size() < 1 && n < 20) begin cyc(); n++; end
        tx_ready = 1'b0;
        chk("t5_in_id", tx_data, 8'h00);
        async_reset("t5_rst");
        txlog.delete();
        grants.delete();

        // All four requesters valid continuously, starting from a fresh pointer.
        req_valid = 4'b1111;
        req_data  = {8'h30, 8'h20, 8'h10, 8'h00};
        tx_ready  = 1'b1;
        run_until(20, 200, "t2_done");
        req_valid = '0;
        for (int f = 0; f < 5; f++) begin
            chk("t2_grant", grants[f], f % 4);
            chk("t2_sync", txlog[4*f], 8'hA5);
            chk("t2_id", txlog[4*f+1], f % 4);
            chk("t2_data", txlog[4*f+2], 8'h10 * (f % 4));
            chk("t2_csum", txlog[4*f+3], txlog[4*f] ^ txlog[4*f+1] ^ txlog[4*f+2]);
        end
        repeat (3) cyc();

        // Randomized traffic with one asynchronous reset partway through.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (c == 1500) async_reset("rand_rst");
            req_valid = N'($urandom);
            req_data  = $urandom;
            tx_ready  = ($urandom_range(0, 9) < 7);
        end
        req_valid = '0;
        tx_ready  = 1'b1;
        repeat (10) cyc();
        chk("drain_busy", busy, 0);
        chk("drain_tx_valid", tx_valid, 0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
